tpu_top: RTL and testbench
==========================

// Module: tpu_top
// PURPOSE
//  Top level of the TPU matrix-multiply engine: computes C = A(m x k) * B(k x n), with up to 32x32x32 signed int8 operands.
//  Operands stream in one column of A and one row of B per cycle from the global buffers.
//  A 32x32 output-stationary MAC array accumulates the products; C is then streamed out one row per cycle on gbuff_out.
//  A stimulus/checker model drives and checks it as the unit under test.
// PARAMETERS
//  LANES   32  vector lanes per 256-bit buffer word (= array dimension)
//  DW      8   operand/result lane width (signed)
//  ACCW    21  accumulator width (16-bit product + 5 bits of growth for 32 terms)
// PORTS
//  clk        in   1    rising-edge clock; single clock domain
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    operand beat valid; high for k consecutive cycles per job
//  gbuff_a    in   256  lane i (bits 8i+7:8i) = A[i][t], signed int8
//  gbuff_b    in   256  lane j (bits 8j+7:8j) = B[t][j], signed int8
//  m          in   5    rows of A / C; sampled on first in_valid beat
//  n          in   5    columns of B / C; sampled on first in_valid beat
//  k          in   5    inner dimension; sampled on first in_valid beat
//  gbuff_out  out  256  lane j = C[r][j] saturated to int8, for output row r
//  out_valid  out  1    gbuff_out holds a valid C row
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - FSM goes to IDLE.
//    - out_valid=0, gbuff_out=0.
//    - All accumulators, counters and latched dims are cleared.
//  - Dimension encoding: m/n/k value 0 means 32; values 1..31 are literal.
//  - FSM states:
//    - IDLE: the first in_valid=1 cycle latches m,n,k and clears all accumulators.
//      That same beat is accumulated as t=0. Go to LOAD; if k==1, go directly to OUT.
//    - LOAD: each in_valid=1 beat does acc[i][j] += A[i][t]*B[t][j] for all i,j, then t increments.
//      After beat t=k-1 is accumulated, go to OUT.
//      in_valid=0 in LOAD stalls: no accumulation, t is held.
//    - OUT: drive rows r=0..m-1, one per cycle, on consecutive cycles.
//      out_valid=1 exactly m cycles. After row m-1, return to IDLE.
//  - Latency: the first out_valid cycle is the 2nd clock edge after the edge that samples the final in_valid beat.
//    That is, one idle cycle for the final accumulate, then registered output.
//  - Outputs are registered. When out_valid=0, gbuff_out=0.
//  - Arithmetic:
//    - Signed 8x8 -> 16-bit product, sign-extended into a 21-bit accumulator; no overflow is possible.
//    - Output lane = saturate(acc) to [-128,127].
//  - Masking:
//    - A lanes i>=m and B lanes j>=n are treated as 0.
//    - gbuff_out lanes j>=n are 0.
//  - in_valid asserted during OUT is ignored. A new job starts only from IDLE; the first accepted beat is the first in_valid=1 cycle in IDLE.
//  - m,n,k changes after the first beat of a job are ignored.
//  - Reset mid-LOAD or mid-OUT aborts the job: out_valid drops immediately (async) and no partial rows appear after reset.
//  - Back-to-back jobs: in_valid may rise in the first IDLE cycle after the last output row. The accumulator clear on that first beat guarantees no carry-over.
// TESTING
//  - 1x1x1: m=n=k=1, a lane0=3, b lane0=-4 -> one out_valid beat, lane0=0xF4 (-12), other lanes 0.
//  - Identity: m=n=k=32 (code 0), A=I, B row t = t in every lane -> row r of C is all lanes = r. 32 out_valid cycles, first one 2 cycles after the last in beat.
//  - Saturation: m=n=1, k=32, all A=B=127 -> C=516128, lane0 out=0x7F. All A=127, B=-128 -> 0x80.
//  - Masking: m=2, n=3, k=4, random data including nonzero junk in unused lanes -> exactly 2 rows out; lanes >=3 zero; values match a golden model that ignores the junk.
//  - Stall + back-to-back: insert in_valid=0 gaps mid-LOAD -> same result as gapless. Start a second job right after OUT -> no accumulator carry-over.
//  - Reset: assert rst_n=0 mid-OUT -> out_valid=0 and gbuff_out=0 immediately. A fresh job afterward is correct.

Source files
------------

// File: rtl/tpu_top_if.sv
// Operand/result bus of the TPU matrix-multiply engine.
// The master drives operand beats and job dimensions; the slave returns C rows.
interface tpu_top_if #(
  parameter int unsigned Lanes = 32,
  parameter int unsigned Dw    = 8
);
  localparam int unsigned DimW = $clog2(Lanes);

  logic                  in_valid;
  logic [Lanes*Dw-1:0]   gbuff_a;
  logic [Lanes*Dw-1:0]   gbuff_b;
  logic [DimW-1:0]       m;
  logic [DimW-1:0]       n;
  logic [DimW-1:0]       k;
  logic [Lanes*Dw-1:0]   gbuff_out;
  logic                  out_valid;

  modport master (
    output in_valid, gbuff_a, gbuff_b, m, n, k,
    input  gbuff_out, out_valid
  );

  modport slave (
    input  in_valid, gbuff_a, gbuff_b, m, n, k,
    output gbuff_out, out_valid
  );
endinterface

// File: rtl/tpu_top.sv
// Output-stationary int8 matrix-multiply engine: C = A(m x k) * B(k x n), up to 32x32x32.
// One A column and one B row stream in per beat; C leaves one saturated row per cycle.
module tpu_top #(
  parameter int unsigned Lanes = 32,
  parameter int unsigned Dw    = 8,
  parameter int unsigned AccW  = 21
) (
  input logic      clk,
  input logic      rst_n,
  tpu_top_if.slave bus
);
  localparam int unsigned DimW = $clog2(Lanes);
  localparam int unsigned CntW = DimW + 1;
  localparam int unsigned PrW  = 2 * Dw;

  localparam logic signed [AccW-1:0] SatMax = AccW'((2 ** (Dw - 1)) - 1);
  localparam logic signed [AccW-1:0] SatMin = ~SatMax;

  typedef enum logic [1:0] {StIdle, StLoad, StFin, StOut} state_e;

  state_e state_q, state_d;

  logic [CntW-1:0] m_q, n_q, k_q;
  logic [CntW-1:0] m_in, n_in, k_in;
  logic [CntW-1:0] m_eff, n_eff;
  logic [CntW-1:0] t_q, t_d;
  logic [CntW-1:0] r_q, r_d;

  logic beat_first;
  logic beat_acc;
  logic out_row;

  logic signed [Dw-1:0]   a_lane [Lanes];
  logic signed [Dw-1:0]   b_lane [Lanes];
  logic signed [AccW-1:0] acc_q  [Lanes][Lanes];

  logic [Lanes*Dw-1:0] row_d;
  logic [Lanes*Dw-1:0] out_q;
  logic                out_valid_q;

  // Dimension code 0 stands for the full array size.
  function automatic logic [CntW-1:0] dim_dec(input logic [DimW-1:0] code);
    return (code == '0) ? CntW'(Lanes) : {1'b0, code};
  endfunction

  function automatic logic signed [AccW-1:0] mac_term(input logic signed [Dw-1:0] a,
                                                      input logic signed [Dw-1:0] b);
    logic signed [PrW-1:0] p;
    p = PrW'(a) * PrW'(b);
    return AccW'(p);
  endfunction

  function automatic logic [Dw-1:0] sat(input logic signed [AccW-1:0] v);
    if (v > SatMax) begin
      return SatMax[Dw-1:0];
    end else if (v < SatMin) begin
      return SatMin[Dw-1:0];
    end
    return v[Dw-1:0];
  endfunction

  assign m_in = dim_dec(bus.m);
  assign n_in = dim_dec(bus.n);
  assign k_in = dim_dec(bus.k);

  // The first beat is masked with the live dimensions; later beats use the latched ones.
  assign m_eff = beat_first ? m_in : m_q;
  assign n_eff = beat_first ? n_in : n_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          state_d = (k_in == CntW'(1)) ? StFin : StLoad;
        end
      end
      StLoad: begin
        if (bus.in_valid && ((t_q + CntW'(1)) == k_q)) begin
          state_d = StFin;
        end
      end
      StFin: state_d = StOut;
      StOut: begin
        if ((r_q + CntW'(1)) == m_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control outputs and counter updates.
  always_comb begin
    beat_first = 1'b0;
    beat_acc   = 1'b0;
    out_row    = 1'b0;
    t_d        = '0;
    r_d        = '0;
    unique case (state_q)
      StIdle: begin
        beat_first = bus.in_valid;
        beat_acc   = bus.in_valid;
        t_d        = bus.in_valid ? CntW'(1) : '0;
      end
      StLoad: begin
        beat_acc = bus.in_valid;
        t_d      = bus.in_valid ? (t_q + CntW'(1)) : t_q;
      end
      StFin: begin
        t_d = '0;
      end
      StOut: begin
        out_row = 1'b1;
        r_d     = r_q + CntW'(1);
      end
      default: begin
        t_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0;
      n_q <= '0;
      k_q <= '0;
      t_q <= '0;
      r_q <= '0;
    end else begin
      if (beat_first) begin
        m_q <= m_in;
        n_q <= n_in;
        k_q <= k_in;
      end
      t_q <= t_d;
      r_q <= r_d;
    end
  end

  always_comb begin
    for (int i = 0; i < Lanes; i++) begin
      a_lane[i] = (CntW'(i) < m_eff) ? bus.gbuff_a[i*Dw +: Dw] : '0;
      b_lane[i] = (CntW'(i) < n_eff) ? bus.gbuff_b[i*Dw +: Dw] : '0;
    end
  end

  // The first beat of a job overwrites instead of accumulating, so no job inherits state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Lanes; i++) begin
        for (int j = 0; j < Lanes; j++) begin
          acc_q[i][j] <= '0;
        end
      end
    end else if (beat_acc) begin
      for (int i = 0; i < Lanes; i++) begin
        for (int j = 0; j < Lanes; j++) begin
          acc_q[i][j] <= (beat_first ? '0 : acc_q[i][j]) + mac_term(a_lane[i], b_lane[j]);
        end
      end
    end
  end

  always_comb begin
    row_d = '0;
    for (int j = 0; j < Lanes; j++) begin
      if (CntW'(j) < n_q) begin
        row_d[j*Dw +: Dw] = sat(acc_q[r_q[DimW-1:0]][j]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= out_row;
      out_q       <= out_row ? row_d : '0;
    end
  end

  assign bus.gbuff_out = out_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_tpu_top.sv
// Directed self-checking bench for tpu_top: small jobs, identity, saturation, masking,
// stalls, back-to-back jobs and reset during output.
module tb_tpu_top;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  tpu_top_if #(.Lanes(32), .Dw(8)) bus ();

  tpu_top #(
    .Lanes(32),
    .Dw   (8),
    .AccW (21)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [255:0] a_mem    [32];
  logic [255:0] b_mem    [32];
  logic [255:0] exp_rows [32];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check($sformatf("%s idle valid", tag), 256'(bus.out_valid), 256'd0);
    check($sformatf("%s idle out", tag), bus.gbuff_out, '0);
  endtask

  // Golden C row r: only A lane r and B lanes < nn over beats < kk contribute.
  function automatic logic [255:0] model_row(input int r, input int nn, input int kk);
    logic [255:0]     row;
    logic signed [7:0] av;
    logic signed [7:0] bv;
    int               s;
    row = '0;
    for (int j = 0; j < nn; j++) begin
      s = 0;
      for (int t = 0; t < kk; t++) begin
        av = a_mem[t][8*r +: 8];
        bv = b_mem[t][8*j +: 8];
        s += int'(av) * int'(bv);
      end
      if (s > 127) s = 127;
      else if (s < -128) s = -128;
      row[8*j +: 8] = 8'(s);
    end
    return row;
  endfunction

  task automatic fill_junk();
    for (int t = 0; t < 32; t++) begin
      for (int i = 0; i < 32; i++) begin
        a_mem[t][8*i +: 8] = 8'(i * 7 + t * 13 - 50);
        b_mem[t][8*i +: 8] = 8'(i * 11 - t * 5 + 3);
      end
    end
  endtask

  task automatic load_model(input int mm, input int nn, input int kk);
    for (int r = 0; r < 32; r++) begin
      exp_rows[r] = (r < mm) ? model_row(r, nn, kk) : '0;
    end
  endtask

  // Streams kk beats starting at the current negedge, then checks latency and all rows.
  // Returns at the negedge inside the first idle cycle so a next job can start at once.
  task automatic run_job(input string tag, input int mm, input int nn, input int kk,
                         input bit gaps, input bit poke, input int abort_at);
    for (int t = 0; t < kk; t++) begin
      if (gaps && (t == 1 || t == 3)) begin
        bus.in_valid = 1'b0;
        bus.gbuff_a  = {32{8'h5A}};
        bus.gbuff_b  = {32{8'hA5}};
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.gbuff_a  = a_mem[t];
      bus.gbuff_b  = b_mem[t];
      if (t == 0) begin
        bus.m = 5'(mm);
        bus.n = 5'(nn);
        bus.k = 5'(kk);
      end else begin
        bus.m = 5'(mm + 3);
        bus.n = 5'(nn + 5);
        bus.k = 5'(kk + 7);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check($sformatf("%s lat1 valid", tag), 256'(bus.out_valid), 256'd0);
    @(negedge clk);
    check($sformatf("%s lat2 valid", tag), 256'(bus.out_valid), 256'd0);
    if (poke) begin
      bus.in_valid = 1'b1;
      bus.gbuff_a  = '1;
      bus.gbuff_b  = '1;
    end
    for (int r = 0; r < mm; r++) begin
      @(negedge clk);
      check($sformatf("%s valid r%0d", tag, r), 256'(bus.out_valid), 256'd1);
      check($sformatf("%s row%0d", tag, r), bus.gbuff_out, exp_rows[r]);
      bus.in_valid = poke && (r < mm - 1);
      if (r == abort_at) begin
        rst_n = 1'b0;
        #1;
        check($sformatf("%s abort valid", tag), 256'(bus.out_valid), 256'd0);
        check($sformatf("%s abort out", tag), bus.gbuff_out, '0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.gbuff_a  = '0;
    bus.gbuff_b  = '0;
    bus.m        = '0;
    bus.n        = '0;
    bus.k        = '0;
    #1 rst_n = 1'b0;
    #2;
    check("reset valid", 256'(bus.out_valid), 256'd0);
    check("reset out", bus.gbuff_out, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_check("post reset");

    // 1x1x1: 3 * -4 = -12
    a_mem[0]    = 256'h03;
    b_mem[0]    = 256'hFC;
    exp_rows[0] = 256'hF4;
    run_job("one", 1, 1, 1, 1'b0, 1'b0, -1);
    idle_check("one");

    // Identity A, B row t = t in every lane: C row r = r everywhere.
    for (int t = 0; t < 32; t++) begin
      a_mem[t]    = 256'd1 << (8 * t);
      b_mem[t]    = {32{8'(t)}};
      exp_rows[t] = {32{8'(t)}};
    end
    run_job("ident", 32, 32, 32, 1'b0, 1'b0, -1);
    idle_check("ident");

    // 32 * 127 * 127 = 516128 saturates high.
    for (int t = 0; t < 32; t++) begin
      a_mem[t] = {32{8'h7F}};
      b_mem[t] = {32{8'h7F}};
    end
    exp_rows[0] = 256'h7F;
    run_job("sat hi", 1, 1, 32, 1'b0, 1'b0, -1);
    idle_check("sat hi");

    // 32 * 127 * -128 saturates low; then an immediate 1x1x1 job must see no carry-over.
    for (int t = 0; t < 32; t++) begin
      b_mem[t] = {32{8'h80}};
    end
    exp_rows[0] = 256'h80;
    run_job("sat lo", 1, 1, 32, 1'b0, 1'b0, -1);
    a_mem[0]    = 256'h03;
    b_mem[0]    = 256'hFC;
    exp_rows[0] = 256'hF4;
    run_job("b2b", 1, 1, 1, 1'b0, 1'b0, -1);
    idle_check("b2b");

    // Masking with junk in unused lanes, in_valid held high during output.
    fill_junk();
    load_model(2, 3, 4);
    run_job("mask", 2, 3, 4, 1'b0, 1'b1, -1);
    idle_check("mask");

    // Same job with stalls inside the load phase.
    run_job("stall", 2, 3, 4, 1'b1, 1'b0, -1);
    idle_check("stall");

    // Reset after the second output row, then a fresh job.
    load_model(4, 4, 2);
    run_job("abort", 4, 4, 2, 1'b0, 1'b0, 1);
    idle_check("after abort a");
    idle_check("after abort b");
    idle_check("after abort c");
    load_model(2, 3, 4);
    run_job("fresh", 2, 3, 4, 1'b0, 1'b0, -1);
    idle_check("fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
